// File: rtl/mux_nto1_reg.sv
// ---------------------------------------------------------------------------
// mux_nto1_reg
//   Registered N-to-1 word multiplexer with a held channel select. This is the
//   pipelined replacement for the single-cycle 2:1 word mux. It is used for
//   forwarding and writeback source selection, where the chosen word has to
//   arrive one clock later.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset
//   in_bus     NUM_IN packed channels; channel k = in_bus[k*WIDTH +: WIDTH]
//   in_valid   qualifies the current in_bus contents
//   sel        new channel select
//   sel_load   capture sel into the held select (also steers this cycle)
//   stall      freeze out / out_valid; the select register still loads
//   err_clr    clear the sticky out-of-range flag
//   out        registered selected word
//   out_valid  out holds a valid selected word
//   sel_q      currently held select
//   sel_err    sticky: an out-of-range select was used in a transfer cycle
// ---------------------------------------------------------------------------
module mux_nto1_reg #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 4,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_load,
    input  logic                    stall,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        sel_q,
    output logic                    sel_err
);

    // The channel count is held one bit wider than the select. That way the
    // range check also covers NUM_IN == 2**SEL_W, and select values are never
    // truncated or wrapped.
    localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];

    logic [SEL_W-1:0] sel_hold_q, sel_hold_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;

    logic [SEL_W-1:0] eff_sel;
    logic             eff_in_range;
    logic [WIDTH-1:0] chan_word;
    logic             err_event;

    // A load bypasses the select register, so it steers the capture made on
    // this same edge.
    assign eff_sel      = sel_load ? sel : sel_hold_q;
    assign eff_in_range = ({1'b0, eff_sel} < NUM_IN_W);

    always_comb begin
        chan_word = DEFAULT_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if ({1'b0, eff_sel} == (SEL_W+1)'(k)) begin
                chan_word = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        sel_hold_d  = sel_load ? sel : sel_hold_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        err_event   = 1'b0;

        if (!stall) begin
            if (eff_in_range) begin
                // out still captures the word when in_valid is low; consumers
                // must qualify it with out_valid.
                out_d       = chan_word;
                out_valid_d = in_valid;
            end else begin
                out_d       = DEFAULT_VAL;
                out_valid_d = 1'b0;
                err_event   = 1'b1;
            end
        end

        // If an error event and a clear happen together, the set wins.
        if (err_event) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end else begin
            sel_err_d = sel_err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_hold_q  <= '0;
            out_q       <= DEFAULT_VAL;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            sel_hold_q  <= sel_hold_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sel_q     = sel_hold_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_nto1_reg
//   Two instances share one set of stimulus:
//     u_mux4 : NUM_IN=4, SEL_W=2, DEFAULT_VAL=0
//     u_mux3 : NUM_IN=3, SEL_W=2, DEFAULT_VAL=A5A50F0F (select 3 out of range)
//   Inputs change on the falling edge and outputs are compared on the falling
//   edge that follows each rising edge.
// ---------------------------------------------------------------------------
module tb_mux_nto1_reg;

    localparam logic [31:0] DFLT3 = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        sel_load = 1'b0;
    logic        stall = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] ch [4];

    logic [127:0] in_bus4;
    logic [95:0]  in_bus3;

    logic [31:0] out4, out3;
    logic        out_valid4, out_valid3;
    logic [1:0]  sel_q4, sel_q3;
    logic        sel_err4, sel_err3;

    assign in_bus4 = {ch[3], ch[2], ch[1], ch[0]};
    assign in_bus3 = in_bus4[95:0];

    always #5 clk = ~clk;

    mux_nto1_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEFAULT_VAL(32'h0)) u_mux4 (
        .clk(clk), .rst(rst), .in_bus(in_bus4), .in_valid(in_valid), .sel(sel),
        .sel_load(sel_load), .stall(stall), .err_clr(err_clr),
        .out(out4), .out_valid(out_valid4), .sel_q(sel_q4), .sel_err(sel_err4)
    );

    mux_nto1_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(DFLT3)) u_mux3 (
        .clk(clk), .rst(rst), .in_bus(in_bus3), .in_valid(in_valid), .sel(sel),
        .sel_load(sel_load), .stall(stall), .err_clr(err_clr),
        .out(out3), .out_valid(out_valid3), .sel_q(sel_q3), .sel_err(sel_err3)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model. Index 0 is the 4-input instance, index 1 the 3-input one.
    int          n_in [2] = '{4, 3};
    logic [31:0] dflt [2] = '{32'h0, DFLT3};
    logic [31:0] m_out [2];
    logic        m_vld [2];
    logic        m_err [2];
    int          m_sel [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_out[d] = dflt[d];
            m_vld[d] = 1'b0;
            m_err[d] = 1'b0;
            m_sel[d] = 0;
        end
    endtask

    // Applies the rules for one rising edge, using the inputs as they stood
    // just before that edge.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int  eff;
            bit  bad;
            eff = sel_load ? int'(sel) : m_sel[d];
            bad = (!stall) && (eff >= n_in[d]);
            if (!stall) begin
                if (eff < n_in[d]) begin
                    m_out[d] = ch[eff];
                    m_vld[d] = in_valid;
                end else begin
                    m_out[d] = dflt[d];
                    m_vld[d] = 1'b0;
                end
            end
            if (bad)          m_err[d] = 1'b1;
            else if (err_clr) m_err[d] = 1'b0;
            if (sel_load)     m_sel[d] = int'(sel);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk_model();
        chk("m4.out",       out4,             m_out[0]);
        chk("m4.out_valid", 32'(out_valid4),  32'(m_vld[0]));
        chk("m4.sel_q",     32'(sel_q4),      32'(m_sel[0]));
        chk("m4.sel_err",   32'(sel_err4),    32'(m_err[0]));
        chk("m3.out",       out3,             m_out[1]);
        chk("m3.out_valid", 32'(out_valid3),  32'(m_vld[1]));
        chk("m3.sel_q",     32'(sel_q3),      32'(m_sel[1]));
        chk("m3.sel_err",   32'(sel_err3),    32'(m_err[1]));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".out4"},   out4,            32'h0);
        chk({tag, ".vld4"},   32'(out_valid4), 32'h0);
        chk({tag, ".selq4"},  32'(sel_q4),     32'h0);
        chk({tag, ".err4"},   32'(sel_err4),   32'h0);
        chk({tag, ".out3"},   out3,            DFLT3);
        chk({tag, ".vld3"},   32'(out_valid3), 32'h0);
        chk({tag, ".selq3"},  32'(sel_q3),     32'h0);
        chk({tag, ".err3"},   32'(sel_err3),   32'h0);
    endtask

    // Raises rst between clock edges and checks that the outputs clear before
    // any edge arrives. rst is released on the next falling edge.
    task automatic async_reset(input logic with_stall);
        stall = with_stall;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        model_reset();
    endtask

    task automatic drive(input logic ld, input logic [1:0] s, input logic st,
                         input logic iv, input logic clr);
        sel_load = ld;
        sel      = s;
        stall    = st;
        in_valid = iv;
        err_clr  = clr;
    endtask

    typedef struct {
        logic        ld;
        logic [1:0]  s;
        logic        st;
        logic        iv;
        logic [31:0] c2;
        logic [31:0] e_out;
        logic        e_vld;
        logic [1:0]  e_selq;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // Directed table for the 4-input instance: bypass, hold, stall, valid
        // qualifier, and a back-to-back sweep.
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 1'b1, 32'h33333333, 32'h33333333, 1'b1, 2'd2};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 1'b1, 32'h33333333, 32'h33333333, 1'b1, 2'd2};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 1'b1, 32'h33333333, 32'h33333333, 1'b1, 2'd2};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h33333333, 1'b1, 2'd2};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h33333333, 1'b1, 2'd2};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h33333333, 1'b1, 2'd2};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 2'd2};
        tbl[7]  = '{1'b1, 2'd0, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 2'd0};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h11111111, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 2'd3, 1'b0, 1'b1, 32'hDEADBEEF, 32'h44444444, 1'b1, 2'd3};
        tbl[10] = '{1'b1, 2'd1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h22222222, 1'b0, 2'd1};
        tbl[11] = '{1'b1, 2'd0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h11111111, 1'b1, 2'd0};
        tbl[12] = '{1'b1, 2'd1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h22222222, 1'b1, 2'd1};
        tbl[13] = '{1'b1, 2'd2, 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 2'd2};
        tbl[14] = '{1'b1, 2'd3, 1'b0, 1'b1, 32'hDEADBEEF, 32'h44444444, 1'b1, 2'd3};

        ch[0] = 32'h11111111;
        ch[1] = 32'h22222222;
        ch[2] = 32'h33333333;
        ch[3] = 32'h44444444;

        // Power-on reset
        #1 rst = 1'b1;
        #2;
        chk_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Get out_valid=1 and sel_q=2, then reset between edges during a stall.
        drive(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
        step();
        chk("pre_rst.vld4",  32'(out_valid4), 32'h1);
        chk("pre_rst.selq4", 32'(sel_q4),     32'h2);
        async_reset(1'b1);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].ld, tbl[i].s, tbl[i].st, tbl[i].iv, 1'b0);
            ch[2] = tbl[i].c2;
            step();
            chk($sformatf("tbl%0d.out4", i),  out4,             tbl[i].e_out);
            chk($sformatf("tbl%0d.vld4", i),  32'(out_valid4),  32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d.selq4", i), 32'(sel_q4),      32'(tbl[i].e_selq));
            chk($sformatf("tbl%0d.err4", i),  32'(sel_err4),    32'h0);
            chk_model();
        end

        // Out-of-range handling on the 3-input instance
        ch[2] = 32'h33333333;
        async_reset(1'b0);

        drive(1'b1, 2'd3, 1'b0, 1'b1, 1'b0); step();
        chk("oor.out3",  out3,            DFLT3);
        chk("oor.vld3",  32'(out_valid3), 32'h0);
        chk("oor.err3",  32'(sel_err3),   32'h1);
        chk("oor.selq3", 32'(sel_q3),     32'h3);

        drive(1'b1, 2'd1, 1'b0, 1'b1, 1'b0); step();
        chk("recov.out3", out3,            32'h22222222);
        chk("recov.vld3", 32'(out_valid3), 32'h1);
        chk("recov.err3", 32'(sel_err3),   32'h1);

        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0); step();
        chk("sticky.err3", 32'(sel_err3), 32'h1);

        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b1); step();
        chk("clr.err3", 32'(sel_err3), 32'h0);
        chk("clr.out3", out3,          32'h22222222);

        // An error event and err_clr in the same cycle: the set wins.
        drive(1'b1, 2'd3, 1'b0, 1'b1, 1'b0); step();
        chk("sw_set.err3", 32'(sel_err3), 32'h1);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b1); step();
        chk("sw_both.err3",  32'(sel_err3), 32'h1);
        chk("sw_both.selq3", 32'(sel_q3),   32'h3);
        drive(1'b1, 2'd0, 1'b0, 1'b1, 1'b1); step();
        chk("sw_clr.err3", 32'(sel_err3), 32'h0);
        chk("sw_clr.out3", out3,          32'h11111111);

        // A stalled cycle does not evaluate the range check.
        drive(1'b1, 2'd3, 1'b1, 1'b1, 1'b0); step();
        chk("st_oor.err3",  32'(sel_err3),   32'h0);
        chk("st_oor.selq3", 32'(sel_q3),     32'h3);
        chk("st_oor.out3",  out3,            32'h11111111);
        chk("st_oor.vld3",  32'(out_valid3), 32'h1);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0); step();
        chk("st_rel.err3", 32'(sel_err3), 32'h1);
        chk("st_rel.out3", out3,          DFLT3);
        chk_model();

        // Randomised run against the model
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset(1'($urandom_range(0, 1)));
            sel_load = 1'($urandom_range(0, 1));
            sel      = 2'($urandom_range(0, 3));
            stall    = ($urandom_range(0, 3) == 0);
            in_valid = 1'($urandom_range(0, 1));
            err_clr  = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < 4; k++) ch[k] = $urandom;
            step();
            chk_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
